// File: rtl/sequential_divider.sv
// sequential_divider: iterative restoring divider with a start/busy/done handshake, one quotient bit per enabled cycle.
// Define SEQUENTIAL_DIVIDER_SIGNED_EN to treat operands and results as two's complement.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_operand_1,
  input  logic [WIDTH-1:0] i_operand_2,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_op1_mag;
  logic [WIDTH-1:0] w_op2_mag;
  logic [WIDTH:0]   w_shift;
  logic             w_borrow;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic [WIDTH-1:0] w_quo_mag;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quo_final;
  logic [WIDTH-1:0] w_rem_final;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // The core divides magnitudes; re-negating a magnitude restores the original dividend for divide by zero.
  assign w_op1_mag   = i_operand_1[WIDTH-1] ? -i_operand_1 : i_operand_1;
  assign w_op2_mag   = i_operand_2[WIDTH-1] ? -i_operand_2 : i_operand_2;
  assign w_quo_final = (r_neg_q && !r_dbz) ? -w_quo_mag : w_quo_mag;
  assign w_rem_final = r_neg_r ? -w_rem_mag : w_rem_mag;
`else
  assign w_op1_mag   = i_operand_1;
  assign w_op2_mag   = i_operand_2;
  assign w_quo_final = w_quo_mag;
  assign w_rem_final = w_rem_mag;
`endif

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_step   = (r_state == RUN) && i_enable;
  assign w_last   = r_dbz || (r_count == CW'(1));

  // When the trial does not borrow, the true difference is below the divisor, so the low WIDTH bits are exact.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_borrow   = w_shift < {1'b0, r_dvs};
  assign w_diff     = w_shift[WIDTH-1:0] - r_dvs;
  assign w_step_rem = w_borrow ? w_shift[WIDTH-1:0] : w_diff;
  assign w_step_quo = {r_dvd[WIDTH-2:0], ~w_borrow};

  always_comb begin
    w_quo_mag = w_step_quo;
    w_rem_mag = w_step_rem;
    if (r_dbz) begin
      w_quo_mag = '1;
      w_rem_mag = r_dvd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = RUN;
      RUN:     if (i_enable && w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != IDLE);
    o_done = (r_state == DONE);
  end

  // A zero divisor still spends one enabled RUN cycle, so done appears one cycle after the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_rem         <= '0;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_dbz         <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_dvd         <= w_op1_mag;
      r_dvs         <= w_op2_mag;
      r_rem         <= '0;
      r_count       <= CW'(WIDTH);
      r_dbz         <= (i_operand_2 == '0);
      r_div_by_zero <= 1'b0;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
      r_neg_q       <= i_operand_1[WIDTH-1] ^ i_operand_2[WIDTH-1];
      r_neg_r       <= i_operand_1[WIDTH-1];
`endif
    end else if (w_step) begin
      if (!r_dbz) begin
        r_rem   <= w_step_rem;
        r_dvd   <= w_step_quo;
        r_count <= r_count - CW'(1);
      end
      if (w_last) begin
        r_quotient    <= w_quo_final;
        r_remainder   <= w_rem_final;
        r_div_by_zero <= r_dbz;
      end
    end
  end

  assign o_div_by_zero = r_div_by_zero;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;

endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: randomized and directed checks of sequential_divider against an arithmetic reference model.
module tb_sequential_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [W-1:0] quo;
  logic [W-1:0] rem;

  int checks = 0;
  int errors = 0;

  sequential_divider #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_enable      (enable),
    .i_operand_1   (op1),
    .i_operand_2   (op2),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (dbz),
    .o_quotient    (quo),
    .o_remainder   (rem)
  );

  always #5 clk = ~clk;

  // Reference results straight from the arithmetic definition of division.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        q = a;
        r = '0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
`else
      q = a / b;
      r = a % b;
      if (sa == sb + 1) q = a / b;
`endif
    end
  endfunction

  // Launch one division from IDLE and return once done is seen (or the cycle budget expires).
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int stallAt, input int stallLen,
                        input int pokeAt, output int lat, output logic busyAfterAccept);
    op1 = a;
    op2 = b;
    start = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busyAfterAccept = busy;
    lat = 0;
    while (!done && lat < 200) begin
      enable = !(lat >= stallAt && lat < stallAt + stallLen);
      if (lat == pokeAt) begin
        start = 1'b1;
        op1 = $urandom;
        op2 = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %b expected 0", dbz); end
    checks++; if (quo !== '0) begin errors++; $display("[TB] FAIL reset_quotient: got %h expected 0", quo); end
    checks++; if (rem !== '0) begin errors++; $display("[TB] FAIL reset_remainder: got %h expected 0", rem); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [W-1:0] eq, er;
    logic ez, b0;
    int lat;
    ref_div(100, 7, eq, er, ez);
    do_div(100, 7, -1, 0, -1, lat, b0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("[TB] FAIL unsigned_busy_rise: got %b expected 1", b0); end
    checks++; if (lat != W) begin errors++; $display("[TB] FAIL unsigned_latency: got %0d expected %0d", lat, W); end
    checks++; if (quo !== eq) begin errors++; $display("[TB] FAIL unsigned_quotient: got %h expected %h", quo, eq); end
    checks++; if (rem !== er) begin errors++; $display("[TB] FAIL unsigned_remainder: got %h expected %h", rem, er); end
    checks++; if (dbz !== ez) begin errors++; $display("[TB] FAIL unsigned_dbz: got %b expected %b", dbz, ez); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL unsigned_busy_fall: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL unsigned_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_div_by_zero();
    logic [W-1:0] eq, er;
    logic ez, b0;
    int lat;
    ref_div(32'h1234, 0, eq, er, ez);
    do_div(32'h1234, 0, -1, 0, -1, lat, b0);
    checks++; if (lat != 1) begin errors++; $display("[TB] FAIL dbz_latency: got %0d expected 1", lat); end
    checks++; if (quo !== eq) begin errors++; $display("[TB] FAIL dbz_quotient: got %h expected %h", quo, eq); end
    checks++; if (rem !== er) begin errors++; $display("[TB] FAIL dbz_remainder: got %h expected %h", rem, er); end
    checks++; if (dbz !== ez) begin errors++; $display("[TB] FAIL dbz_flag: got %b expected %b", dbz, ez); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_and_ignored_start();
    logic [W-1:0] eq, er;
    logic ez, b0;
    int lat;
    ref_div(32'hFFFFFFFF, 32'h10, eq, er, ez);
    do_div(32'hFFFFFFFF, 32'h10, 10, 5, 12, lat, b0);
    checks++; if (lat != W + 5) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected %0d", lat, W + 5); end
    checks++; if (quo !== eq) begin errors++; $display("[TB] FAIL stall_quotient: got %h expected %h", quo, eq); end
    checks++; if (rem !== er) begin errors++; $display("[TB] FAIL stall_remainder: got %h expected %h", rem, er); end
    checks++; if (dbz !== ez) begin errors++; $display("[TB] FAIL stall_dbz: got %b expected %b", dbz, ez); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stall_start_not_queued: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eq, er;
    logic ez, b0;
    int lat;
    do_div(32'd1000, 32'd9, -1, 0, -1, lat, b0);
    // Hold start through the DONE edge: it must be ignored there and accepted only from IDLE.
    op1 = 32'd77777;
    op2 = 32'd123;
    start = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_start_in_done: got %b expected 0", busy); end
    ref_div(32'd77777, 32'd123, eq, er, ez);
    do_div(32'd77777, 32'd123, -1, 0, -1, lat, b0);
    checks++; if (lat != W) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, W); end
    checks++; if (quo !== eq) begin errors++; $display("[TB] FAIL b2b_quotient: got %h expected %h", quo, eq); end
    checks++; if (rem !== er) begin errors++; $display("[TB] FAIL b2b_remainder: got %h expected %h", rem, er); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] eq, er;
    logic ez, b0;
    int lat;
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("[TB] FAIL midreset_dbz: got %b expected 0", dbz); end
    checks++; if (quo !== '0) begin errors++; $display("[TB] FAIL midreset_quotient: got %h expected 0", quo); end
    checks++; if (rem !== '0) begin errors++; $display("[TB] FAIL midreset_remainder: got %h expected 0", rem); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ref_div(50, 5, eq, er, ez);
    do_div(50, 5, -1, 0, -1, lat, b0);
    checks++; if (lat != W) begin errors++; $display("[TB] FAIL postreset_latency: got %0d expected %0d", lat, W); end
    checks++; if (quo !== eq) begin errors++; $display("[TB] FAIL postreset_quotient: got %h expected %h", quo, eq); end
    checks++; if (rem !== er) begin errors++; $display("[TB] FAIL postreset_remainder: got %h expected %h", rem, er); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    logic ez, b0;
    int lat;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      ref_div(a, b, eq, er, ez);
      do_div(a, b, -1, 0, -1, lat, b0);
      checks++; if (quo * b + rem !== a) begin errors++; $display("[TB] FAIL rand_identity[%0d]: got %h*%h+%h expected %h", i, quo, b, rem, a); end
      checks++; if (!(rem < b)) begin errors++; $display("[TB] FAIL rand_rem_bound[%0d]: got %h expected below %h", i, rem, b); end
      checks++; if (quo !== eq || rem !== er) begin errors++; $display("[TB] FAIL rand_model[%0d]: got q=%h r=%h expected q=%h r=%h", i, quo, rem, eq, er); end
      @(posedge clk); #1;
    end
  endtask

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic [W-1:0] qv [3];
    logic [W-1:0] rv [3];
    logic b0;
    int lat;
    av[0] = -32'sd7;        bv[0] = 32'sd2;  qv[0] = -32'sd3;        rv[0] = -32'sd1;
    av[1] = 32'sd7;         bv[1] = -32'sd2; qv[1] = -32'sd3;        rv[1] = 32'sd1;
    av[2] = 32'h80000000;   bv[2] = -32'sd1; qv[2] = 32'h80000000;   rv[2] = '0;
    for (int i = 0; i < 3; i++) begin
      do_div(av[i], bv[i], -1, 0, -1, lat, b0);
      checks++; if (lat != W) begin errors++; $display("[TB] FAIL signed_latency[%0d]: got %0d expected %0d", i, lat, W); end
      checks++; if (quo !== qv[i]) begin errors++; $display("[TB] FAIL signed_quotient[%0d]: got %h expected %h", i, quo, qv[i]); end
      checks++; if (rem !== rv[i]) begin errors++; $display("[TB] FAIL signed_remainder[%0d]: got %h expected %h", i, rem, rv[i]); end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_div_by_zero();
    test_stall_and_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
